// File: rtl/warp_pipe_barrier_pkg.sv
// -----------------------------------------------------------------------------
// warp_pipe_barrier_pkg
//   Shared hart definitions used by the elastic pipeline barriers:
//     WARP_FETCH_LANES  - instruction slots fetched per bundle
//     BUNDLE_SIZE       - width of one decoded bundle lane (ID/IS barrier)
//     IF_ID_WIDTH       - 32-bit instruction word plus compressed flag
//     take_width()      - width of a "lanes consumed" count, $clog2(LANES+1)
//     count_width()     - width of an occupancy count, $clog2(DEPTH+1)
//     ptr_width()       - circular-buffer pointer width, minimum 1
//     consume_e         - what the head entry does in a given cycle
// -----------------------------------------------------------------------------
package warp_pipe_barrier_pkg;

  localparam int WARP_FETCH_LANES = 2;
  localparam int BUNDLE_SIZE      = 64;
  localparam int IF_ID_WIDTH      = 33;

  typedef enum logic [1:0] {
    CONSUME_HOLD  = 2'd0,
    CONSUME_SHIFT = 2'd1,
    CONSUME_POP   = 2'd2
  } consume_e;

  function automatic int take_width(input int lanes);
    return $clog2(lanes + 1);
  endfunction

  function automatic int count_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  // A single-entry buffer still carries a 1-bit pointer that stays at zero.
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/warp_lane_compact.sv
// -----------------------------------------------------------------------------
// warp_lane_compact
//   Combinational head-entry compactor. Given the head bundle and the number of
//   leading lanes consumed, returns the bundle shifted down by that many lanes
//   (vacated upper lanes zero-filled) and a flag saying the whole bundle is
//   used up, in which case the caller pops the entry instead of rewriting it.
// Ports:
//   i_mask  head lane-valid mask (contiguous from lane 0)
//   i_data  head lane payloads, lane k at [k*WIDTH +: WIDTH]
//   i_take  leading lanes consumed this cycle
//   o_mask  shifted lane-valid mask
//   o_data  shifted payloads
//   o_pop   take is non-zero and covers every valid lane
// -----------------------------------------------------------------------------
module warp_lane_compact
  import warp_pipe_barrier_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int LANES = WARP_FETCH_LANES
) (
  input  logic [LANES-1:0]             i_mask,
  input  logic [LANES*WIDTH-1:0]       i_data,
  input  logic [take_width(LANES)-1:0] i_take,
  output logic [LANES-1:0]             o_mask,
  output logic [LANES*WIDTH-1:0]       o_data,
  output logic                         o_pop
);

  localparam int TW = take_width(LANES);

  logic [TW-1:0] lane_cnt_s;

  // Count valid lanes, shift the bundle down and decide between shift and pop
  always_comb begin
    lane_cnt_s = {TW{1'b0}};
    for (int k = 0; k < LANES; k++) begin
      lane_cnt_s = lane_cnt_s + TW'(i_mask[k]);
    end
    // Shifting right by whole lanes zero-fills the vacated top lanes; a take
    // at or beyond LANES simply yields an all-zero entry.
    o_mask = i_mask >> i_take;
    o_data = i_data >> (32'(i_take) * WIDTH);
    // A take larger than the valid-lane count saturates to a full pop.
    o_pop  = (i_take != {TW{1'b0}}) && (i_take >= lane_cnt_s);
  end

endmodule

// File: rtl/warp_pipe_barrier.sv
// -----------------------------------------------------------------------------
// warp_pipe_barrier
//   Elastic multi-lane pipeline barrier. Buffers up to DEPTH bundles of LANES
//   slots in a circular buffer with a valid/ready handshake, a flush, and
//   partial consumption of the head bundle (leading lanes retire while later
//   lanes stay behind and slide down to lane 0).
// Ports:
//   i_clk           clock, rising edge
//   i_rst           asynchronous active-high reset
//   i_flush         discard buffered and incoming bundles
//   i_input_valid   upstream bundle present
//   o_input_ready   space for a bundle (registered state only)
//   i_lane_valid    incoming lane mask, contiguous from lane 0
//   i_lane_data     incoming payloads, lane k at [k*WIDTH +: WIDTH]
//   o_output_valid  head bundle present
//   o_lane_valid    head lane mask (zero when empty)
//   o_lane_data     head payloads (zero when empty)
//   i_output_take   leading head lanes consumed this cycle
//   o_count         occupied entries
// -----------------------------------------------------------------------------
module warp_pipe_barrier
  import warp_pipe_barrier_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int LANES = WARP_FETCH_LANES,
  parameter int DEPTH = 2
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_flush,
  input  logic                          i_input_valid,
  output logic                          o_input_ready,
  input  logic [LANES-1:0]              i_lane_valid,
  input  logic [LANES*WIDTH-1:0]        i_lane_data,
  output logic                          o_output_valid,
  output logic [LANES-1:0]              o_lane_valid,
  output logic [LANES*WIDTH-1:0]        o_lane_data,
  input  logic [take_width(LANES)-1:0]  i_output_take,
  output logic [count_width(DEPTH)-1:0] o_count
);

  localparam int TW = take_width(LANES);
  localparam int CW = count_width(DEPTH);
  localparam int PW = ptr_width(DEPTH);

  logic [LANES-1:0]       mask_r [DEPTH];
  logic [LANES*WIDTH-1:0] data_r [DEPTH];
  logic [PW-1:0]          rd_ptr_r;
  logic [PW-1:0]          wr_ptr_r;
  logic [CW-1:0]          count_r;

  logic                   out_valid_s;
  logic                   ready_s;
  logic                   push_s;
  logic                   write_s;
  logic                   pop_s;
  logic [LANES-1:0]       head_mask_s;
  logic [LANES*WIDTH-1:0] head_data_s;
  logic [LANES-1:0]       shift_mask_s;
  logic [LANES*WIDTH-1:0] shift_data_s;
  logic                   head_pop_s;
  consume_e               consume_s;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] ptr);
    if (ptr == PW'(DEPTH - 1)) begin
      return {PW{1'b0}};
    end else begin
      return ptr + PW'(1);
    end
  endfunction

  // Status and head view, derived from registered state only
  always_comb begin
    out_valid_s = (count_r != {CW{1'b0}});
    ready_s     = (count_r < CW'(DEPTH));
    head_mask_s = mask_r[rd_ptr_r];
    head_data_s = data_r[rd_ptr_r];
  end

  warp_lane_compact #(
    .WIDTH (WIDTH),
    .LANES (LANES)
  ) u_compact (
    .i_mask (head_mask_s),
    .i_data (head_data_s),
    .i_take (i_output_take),
    .o_mask (shift_mask_s),
    .o_data (shift_data_s),
    .o_pop  (head_pop_s)
  );

  // Decide what happens to the head entry and whether a bundle is pushed
  always_comb begin
    consume_s = CONSUME_HOLD;
    if (out_valid_s && !i_flush && (i_output_take != {TW{1'b0}})) begin
      if (head_pop_s) begin
        consume_s = CONSUME_POP;
      end else begin
        consume_s = CONSUME_SHIFT;
      end
    end else begin
      consume_s = CONSUME_HOLD;
    end
    push_s  = i_input_valid && ready_s && !i_flush;
    // An all-empty bundle completes the handshake but occupies no entry.
    write_s = push_s && (|i_lane_valid);
    pop_s   = (consume_s == CONSUME_POP);
  end

  // Pointer and occupancy bookkeeping; flush collapses the buffer to empty
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rd_ptr_r <= {PW{1'b0}};
      wr_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else if (i_flush) begin
      rd_ptr_r <= {PW{1'b0}};
      wr_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (write_s) begin
        wr_ptr_r <= next_ptr(wr_ptr_r);
      end
      if (pop_s) begin
        rd_ptr_r <= next_ptr(rd_ptr_r);
      end
      case ({write_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry storage: write the tail on push, rewrite the head on a partial take.
  // A shifting head is never the write target: a shift needs a non-empty
  // buffer, and then the write pointer differs from the read pointer.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int e = 0; e < DEPTH; e++) begin
        mask_r[e] <= {LANES{1'b0}};
        data_r[e] <= {(LANES*WIDTH){1'b0}};
      end
    end else begin
      if (write_s) begin
        mask_r[wr_ptr_r] <= i_lane_valid;
        data_r[wr_ptr_r] <= i_lane_data;
      end
      if (consume_s == CONSUME_SHIFT) begin
        mask_r[rd_ptr_r] <= shift_mask_s;
        data_r[rd_ptr_r] <= shift_data_s;
      end
    end
  end

  // Outputs are masked by occupancy so stale storage after a flush is hidden
  assign o_input_ready  = ready_s;
  assign o_output_valid = out_valid_s;
  assign o_lane_valid   = out_valid_s ? head_mask_s : {LANES{1'b0}};
  assign o_lane_data    = out_valid_s ? head_data_s : {(LANES*WIDTH){1'b0}};
  assign o_count        = count_r;

endmodule

// File: tb/tb_warp_pipe_barrier.sv
// -----------------------------------------------------------------------------
// tb_warp_pipe_barrier
//   Drives a DEPTH=2 and a DEPTH=3 barrier (LANES=2, WIDTH=32) from the same
//   stimulus. A directed vector table checks the DEPTH=2 instance against
//   fixed expectations; a queue-based reference model checks both instances
//   every cycle, through directed, hand-written and random stimulus.
// -----------------------------------------------------------------------------
module tb_warp_pipe_barrier;

  localparam int W = 32;
  localparam int L = 2;

  typedef struct packed {
    logic [L-1:0]   mask;
    logic [L*W-1:0] data;
  } bundle_t;

  typedef struct packed {
    logic        v;
    logic [1:0]  m;
    logic [63:0] d;
    logic [1:0]  t;
    logic        f;
    logic        ev;
    logic [1:0]  em;
    logic [63:0] ed;
    logic [1:0]  ec;
    logic        er;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [1:0]  lane_valid = 2'b00;
  logic [63:0] lane_data = 64'd0;
  logic [1:0]  take = 2'd0;

  logic        rdy2, ov2, rdy3, ov3;
  logic [1:0]  lv2, lv3, cnt2, cnt3;
  logic [63:0] ld2, ld3;

  bundle_t mq[2][$];
  vec_t    vt[$];
  int      n_checks = 0;
  int      n_fail = 0;

  always #5 clk = ~clk;

  warp_pipe_barrier #(.WIDTH(W), .LANES(L), .DEPTH(2)) dut2 (
    .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_input_valid(in_valid),
    .o_input_ready(rdy2), .i_lane_valid(lane_valid), .i_lane_data(lane_data),
    .o_output_valid(ov2), .o_lane_valid(lv2), .o_lane_data(ld2),
    .i_output_take(take), .o_count(cnt2)
  );

  warp_pipe_barrier #(.WIDTH(W), .LANES(L), .DEPTH(3)) dut3 (
    .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_input_valid(in_valid),
    .o_input_ready(rdy3), .i_lane_valid(lane_valid), .i_lane_data(lane_data),
    .o_output_valid(ov3), .o_lane_valid(lv3), .o_lane_data(ld3),
    .i_output_take(take), .o_count(cnt3)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of bundles; one call per clock edge, using the
  // inputs currently driven and the occupancy before the edge.
  task automatic model_step(input int id, input int depth);
    bundle_t h;
    bundle_t nh;
    int      sz;
    int      n;
    int      ti;
    bit      rdy;
    sz  = mq[id].size();
    rdy = (sz < depth);
    if (flush) begin
      mq[id].delete();
    end else begin
      ti = int'(take);
      if (sz > 0 && ti != 0) begin
        h = mq[id][0];
        n = 0;
        for (int k = 0; k < L; k++) n += int'(h.mask[k]);
        if (ti >= n) begin
          void'(mq[id].pop_front());
        end else begin
          nh = '0;
          for (int k = 0; k < L; k++) begin
            if (k + ti < L) begin
              nh.mask[k]         = h.mask[k + ti];
              nh.data[k*W +: W]  = h.data[(k + ti)*W +: W];
            end
          end
          mq[id][0] = nh;
        end
      end
      if (in_valid && rdy && lane_valid != 2'b00) begin
        nh.mask = lane_valid;
        nh.data = lane_data;
        mq[id].push_back(nh);
      end
    end
  endtask

  task automatic model_check(input int id, input int depth);
    logic        ov, rdy;
    logic [1:0]  lv, cnt;
    logic [63:0] ld;
    logic [1:0]  em;
    logic [63:0] ed;
    int          sz;
    if (id == 0) begin
      ov = ov2; rdy = rdy2; lv = lv2; cnt = cnt2; ld = ld2;
    end else begin
      ov = ov3; rdy = rdy3; lv = lv3; cnt = cnt3; ld = ld3;
    end
    sz = mq[id].size();
    em = (sz > 0) ? mq[id][0].mask : 2'b00;
    ed = (sz > 0) ? mq[id][0].data : 64'd0;
    chk($sformatf("model_d%0d_valid", depth), {63'd0, ov}, {63'd0, (sz > 0)});
    chk($sformatf("model_d%0d_mask", depth), {62'd0, lv}, {62'd0, em});
    chk($sformatf("model_d%0d_data", depth), ld, ed);
    chk($sformatf("model_d%0d_count", depth), {62'd0, cnt}, 64'(sz));
    chk($sformatf("model_d%0d_ready", depth), {63'd0, rdy}, {63'd0, (sz < depth)});
  endtask

  // One clock: drive inputs, advance the model, compare after the edge.
  task automatic cycle(input logic v, input logic [1:0] m, input logic [63:0] d,
                       input logic [1:0] t, input logic f);
    in_valid = v; lane_valid = m; lane_data = d; take = t; flush = f;
    assert (m != 2'b10) else $error("illegal non-contiguous lane mask driven");
    model_step(0, 2);
    model_step(1, 3);
    @(posedge clk);
    @(negedge clk);
    model_check(0, 2);
    model_check(1, 3);
  endtask

  function automatic vec_t mk(input logic v, input logic [1:0] m, input logic [63:0] d,
                              input logic [1:0] t, input logic f, input logic ev,
                              input logic [1:0] em, input logic [63:0] ed,
                              input logic [1:0] ec, input logic er);
    vec_t r;
    r.v = v; r.m = m; r.d = d; r.t = t; r.f = f;
    r.ev = ev; r.em = em; r.ed = ed; r.ec = ec; r.er = er;
    return r;
  endfunction

  initial begin
    logic [63:0] d;
    logic [1:0]  m;
    vec_t        r;

    // Directed table, DEPTH=2; expectations are the outputs after the edge.
    vt.push_back(mk(1, 2'b11, 64'hBBBB0002_AAAA0001, 2'd0, 0, 1, 2'b11, 64'hBBBB0002_AAAA0001, 2'd1, 1));
    vt.push_back(mk(0, 2'b00, 64'h0, 2'd0, 0, 1, 2'b11, 64'hBBBB0002_AAAA0001, 2'd1, 1));
    vt.push_back(mk(0, 2'b00, 64'h0, 2'd1, 0, 1, 2'b01, 64'h00000000_BBBB0002, 2'd1, 1));
    vt.push_back(mk(0, 2'b00, 64'h0, 2'd1, 0, 0, 2'b00, 64'h0, 2'd0, 1));
    vt.push_back(mk(1, 2'b11, 64'hCCCC0002_CCCC0001, 2'd0, 0, 1, 2'b11, 64'hCCCC0002_CCCC0001, 2'd1, 1));
    vt.push_back(mk(1, 2'b11, 64'hDDDD0002_DDDD0001, 2'd0, 0, 1, 2'b11, 64'hCCCC0002_CCCC0001, 2'd2, 0));
    vt.push_back(mk(1, 2'b11, 64'hEEEE0002_EEEE0001, 2'd0, 0, 1, 2'b11, 64'hCCCC0002_CCCC0001, 2'd2, 0));
    vt.push_back(mk(1, 2'b11, 64'hEEEE0002_EEEE0001, 2'd2, 0, 1, 2'b11, 64'hDDDD0002_DDDD0001, 2'd1, 1));
    vt.push_back(mk(1, 2'b11, 64'hEEEE0002_EEEE0001, 2'd2, 0, 1, 2'b11, 64'hEEEE0002_EEEE0001, 2'd1, 1));
    vt.push_back(mk(0, 2'b00, 64'h0, 2'd2, 0, 0, 2'b00, 64'h0, 2'd0, 1));
    vt.push_back(mk(1, 2'b11, 64'hF0F00002_F0F00001, 2'd0, 0, 1, 2'b11, 64'hF0F00002_F0F00001, 2'd1, 1));
    vt.push_back(mk(1, 2'b11, 64'h60600002_60600001, 2'd0, 0, 1, 2'b11, 64'hF0F00002_F0F00001, 2'd2, 0));
    vt.push_back(mk(1, 2'b11, 64'h70700002_70700001, 2'd1, 1, 0, 2'b00, 64'h0, 2'd0, 1));
    vt.push_back(mk(1, 2'b11, 64'h11110002_11110001, 2'd0, 0, 1, 2'b11, 64'h11110002_11110001, 2'd1, 1));
    vt.push_back(mk(1, 2'b11, 64'h22220002_22220001, 2'd2, 1, 0, 2'b00, 64'h0, 2'd0, 1));
    vt.push_back(mk(0, 2'b00, 64'h0, 2'd0, 0, 0, 2'b00, 64'h0, 2'd0, 1));
    vt.push_back(mk(1, 2'b00, 64'h99990002_99990001, 2'd0, 0, 0, 2'b00, 64'h0, 2'd0, 1));
    vt.push_back(mk(1, 2'b01, 64'h00000000_33330001, 2'd0, 0, 1, 2'b01, 64'h00000000_33330001, 2'd1, 1));
    vt.push_back(mk(0, 2'b00, 64'h0, 2'd3, 0, 0, 2'b00, 64'h0, 2'd0, 1));
    vt.push_back(mk(1, 2'b11, 64'h44440002_44440001, 2'd0, 0, 1, 2'b11, 64'h44440002_44440001, 2'd1, 1));
    vt.push_back(mk(1, 2'b11, 64'h55550002_55550001, 2'd0, 0, 1, 2'b11, 64'h44440002_44440001, 2'd2, 0));

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_valid", {63'd0, ov2}, 64'd0);
    chk("reset_mask", {62'd0, lv2}, 64'd0);
    chk("reset_data", ld2, 64'd0);
    chk("reset_count", {62'd0, cnt2}, 64'd0);
    chk("reset_ready", {63'd0, rdy2}, 64'd1);
    rst = 1'b0;

    foreach (vt[i]) begin
      r = vt[i];
      cycle(r.v, r.m, r.d, r.t, r.f);
      chk($sformatf("vec%0d_valid", i), {63'd0, ov2}, {63'd0, r.ev});
      chk($sformatf("vec%0d_mask", i), {62'd0, lv2}, {62'd0, r.em});
      chk($sformatf("vec%0d_data", i), ld2, r.ed);
      chk($sformatf("vec%0d_count", i), {62'd0, cnt2}, {62'd0, r.ec});
      chk($sformatf("vec%0d_ready", i), {63'd0, rdy2}, {63'd0, r.er});
    end

    // Asynchronous reset between edges with the DEPTH=2 buffer full
    in_valid = 1'b1; lane_valid = 2'b11; lane_data = 64'h66660002_66660001; take = 2'd0;
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", {63'd0, ov2}, 64'd0);
    chk("arst_mask", {62'd0, lv2}, 64'd0);
    chk("arst_data", ld2, 64'd0);
    chk("arst_count", {62'd0, cnt2}, 64'd0);
    chk("arst_count_d3", {62'd0, cnt3}, 64'd0);
    mq[0].delete();
    mq[1].delete();
    @(posedge clk);
    @(negedge clk);
    chk("arst_held_count", {62'd0, cnt2}, 64'd0);
    rst = 1'b0;
    in_valid = 1'b0;
    #1 chk("arst_release_ready", {63'd0, rdy2}, 64'd1);

    // Continuous stream: one bundle per cycle, occupancy stays at one
    for (int i = 0; i < 10; i++) begin
      d = {32'hB0000000 | 32'(i), 32'hA0000000 | 32'(i)};
      cycle(1'b1, 2'b11, d, 2'd2, 1'b0);
      chk($sformatf("stream%0d_data", i), ld2, d);
      chk($sformatf("stream%0d_count", i), {62'd0, cnt2}, 64'd1);
      chk($sformatf("stream%0d_data_d3", i), ld3, d);
    end
    cycle(1'b0, 2'b00, 64'd0, 2'd2, 1'b0);
    chk("stream_drained", {63'd0, ov2}, 64'd0);

    // Random traffic against the model on both depths
    for (int i = 0; i < 600; i++) begin
      case ($urandom_range(0, 2))
        0:       m = 2'b00;
        1:       m = 2'b01;
        default: m = 2'b11;
      endcase
      d = {$urandom, $urandom};
      cycle(($urandom_range(0, 3) != 0), m, d, 2'($urandom_range(0, 3)),
            ($urandom_range(0, 15) == 0));
    end
    repeat (6) cycle(1'b0, 2'b00, 64'd0, 2'd3, 1'b0);
    chk("final_empty", {62'd0, cnt2}, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
